// File: rtl/capture_pkg.sv
// capture_pkg: shared types and defaults for capture_sequencer.
//   state_t              capture FSM states
//   SAMPLE_W_DEF/CNT_W_DEF default sample and counter widths
//   FIFO_RST_CYCLES_DEF  default FIFO reset pulse length
package capture_pkg;
  localparam int SAMPLE_W_DEF = 10;
  localparam int CNT_W_DEF = 32;
  localparam int FIFO_RST_CYCLES_DEF = 4;
  typedef enum logic [2:0] {IDLE, FIFO_RST, PREFILL, WAIT_TRIG, POST, DONE} state_t;
endpackage

// File: rtl/capture_sequencer_trigger_qualifier.sv
// trigger_qualifier: level/edge trigger detection on valid ADC samples.
//   clk, rst    clock, synchronous active-high reset
//   clr         accepted arm; reloads trig_prev with ~trig_level
//   trig_in     raw trigger, synchronous to clk
//   trig_level  active level; trig_edge selects edge (1) or level (0) mode
//   adc_ce      sample valid; trig_prev only advances on valid samples
//   trig_event  combinational qualified trigger for the current sample
module trigger_qualifier (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic trig_in,
  input  logic trig_level,
  input  logic trig_edge,
  input  logic adc_ce,
  output logic trig_event
);
  logic trig_prev;
  assign trig_event = adc_ce & (trig_in == trig_level) & (~trig_edge | (trig_prev != trig_level));
  always_ff @(posedge clk) begin
    if (rst) trig_prev <= 1'b0;
    else trig_prev <= clr ? ~trig_level : adc_ce ? trig_in : trig_prev;
  end
endmodule

// File: rtl/capture_sequencer.sv
// capture_sequencer: sequences one acquisition (FIFO reset, pre-trigger fill,
// trigger qualification, post-trigger count) in front of the sample FIFO.
//   inputs : clk, rst, arm, abort, trig_in, trig_level, trig_edge,
//            presamples, number_samples, adc_data, adc_ce, fifo_wr_done
//   outputs: fifo_rst, fifo_wr_data, fifo_wr_ce, fifo_wr_trigger,
//            fifo_circular_depth, armed, triggered, capture_done, overflow
// With CAPTURE_TIMEOUT_EN defined, adds input timeout_cycles and output
// timed_out: a stalled WAIT_TRIG forces the next valid sample as trigger.
module capture_sequencer
  import capture_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int FIFO_RST_CYCLES = FIFO_RST_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arm,
  input  logic                abort,
  input  logic                trig_in,
  input  logic                trig_level,
  input  logic                trig_edge,
  input  logic [CNT_W-1:0]    presamples,
  input  logic [CNT_W-1:0]    number_samples,
  input  logic [SAMPLE_W-1:0] adc_data,
  input  logic                adc_ce,
`ifdef CAPTURE_TIMEOUT_EN
  input  logic [CNT_W-1:0]    timeout_cycles,
  output logic                timed_out,
`endif
  output logic                fifo_rst,
  output logic [SAMPLE_W-1:0] fifo_wr_data,
  output logic                fifo_wr_ce,
  output logic                fifo_wr_trigger,
  output logic [CNT_W-1:0]    fifo_circular_depth,
  input  logic                fifo_wr_done,
  output logic                armed,
  output logic                triggered,
  output logic                capture_done,
  output logic                overflow
);
  localparam int RC_W = FIFO_RST_CYCLES > 1 ? $clog2(FIFO_RST_CYCLES) : 1;
  state_t state, state_n;
  logic [RC_W-1:0] rst_cnt;
  logic [CNT_W-1:0] pre_l, num_l, pre_cnt, post_cnt, pre_inc, post_inc;
  logic start, run, gate, fire, trig_event, force_trig;
  assign start = arm & ~abort & (state == IDLE | state == DONE);
  assign run = state inside {PREFILL, WAIT_TRIG, POST};
  // The sample that coincides with abort or fifo_wr_done is never written.
  assign gate = run & ~abort & ~fifo_wr_done;
  assign fire = (state == WAIT_TRIG) & adc_ce & gate & (trig_event | force_trig);
  assign pre_inc = &pre_cnt ? pre_cnt : pre_cnt + CNT_W'(1);
  assign post_inc = &post_cnt ? post_cnt : post_cnt + CNT_W'(1);
  assign fifo_circular_depth = pre_l;
  assign armed = state == PREFILL | state == WAIT_TRIG;
  assign capture_done = state == DONE;
  trigger_qualifier u_trig (
    .clk(clk), .rst(rst), .clr(start), .trig_in(trig_in), .trig_level(trig_level),
    .trig_edge(trig_edge), .adc_ce(adc_ce), .trig_event(trig_event)
  );
`ifdef CAPTURE_TIMEOUT_EN
  logic [CNT_W-1:0] to_cnt;
  assign force_trig = (timeout_cycles != '0) & (to_cnt == timeout_cycles);
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
      timed_out <= 1'b0;
    end else begin
      to_cnt <= state != WAIT_TRIG ? '0 : (to_cnt == timeout_cycles || &to_cnt) ? to_cnt : to_cnt + CNT_W'(1);
      timed_out <= start ? 1'b0 : timed_out | (fire & force_trig & ~trig_event);
    end
  end
`else
  assign force_trig = 1'b0;
`endif
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE: state_n = start ? FIFO_RST : state;
      FIFO_RST:   state_n = rst_cnt != RC_W'(FIFO_RST_CYCLES - 1) ? FIFO_RST : pre_l == '0 ? WAIT_TRIG : PREFILL;
      PREFILL:    state_n = adc_ce && pre_inc == pre_l ? WAIT_TRIG : PREFILL;
      WAIT_TRIG:  state_n = !fire ? WAIT_TRIG : num_l == CNT_W'(1) ? DONE : POST;
      POST:       state_n = adc_ce && post_inc == num_l ? DONE : POST;
      default:    state_n = IDLE;
    endcase
    if (run && fifo_wr_done) state_n = DONE;
    if (abort) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      fifo_rst <= 1'b1;
      rst_cnt <= '0;
      pre_l <= '0;
      num_l <= '0;
      pre_cnt <= '0;
      post_cnt <= '0;
      fifo_wr_data <= '0;
      fifo_wr_ce <= 1'b0;
      fifo_wr_trigger <= 1'b0;
      triggered <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      fifo_rst <= state_n == FIFO_RST;
      rst_cnt <= state == FIFO_RST ? rst_cnt + RC_W'(1) : '0;
      fifo_wr_data <= adc_data;
      fifo_wr_ce <= adc_ce & gate;
      fifo_wr_trigger <= fire;
      if (start) begin
        pre_l <= presamples;
        num_l <= number_samples == '0 ? CNT_W'(1) : number_samples;
      end
      pre_cnt <= start ? '0 : (state == PREFILL && adc_ce && gate) ? pre_inc : pre_cnt;
      post_cnt <= fire ? CNT_W'(1) : (state == POST && adc_ce && gate) ? post_inc : post_cnt;
      triggered <= start ? 1'b0 : triggered | fire;
      overflow <= start ? 1'b0 : overflow | (run & fifo_wr_done);
    end
  end
endmodule

// File: tb/tb_capture_sequencer.sv
// tb_capture_sequencer: randomized self-checking bench for capture_sequencer.
module tb_capture_sequencer;
  localparam int NC = 260;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst = 1, arm = 0, abort = 0, trig_in = 0, trig_level = 0, trig_edge = 0, adc_ce = 0, fifo_wr_done = 0;
  logic [31:0] presamples = 0, number_samples = 0;
  logic [9:0] adc_data = 0;
  logic fifo_rst, fifo_wr_ce, fifo_wr_trigger, armed, triggered, capture_done, overflow;
  logic [9:0] fifo_wr_data;
  logic [31:0] fifo_circular_depth;
`ifdef CAPTURE_TIMEOUT_EN
  logic [31:0] timeout_cycles = 0;
  logic timed_out;
`endif
  capture_sequencer dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .trig_in(trig_in), .trig_level(trig_level),
    .trig_edge(trig_edge), .presamples(presamples), .number_samples(number_samples),
    .adc_data(adc_data), .adc_ce(adc_ce),
`ifdef CAPTURE_TIMEOUT_EN
    .timeout_cycles(timeout_cycles), .timed_out(timed_out),
`endif
    .fifo_rst(fifo_rst), .fifo_wr_data(fifo_wr_data), .fifo_wr_ce(fifo_wr_ce),
    .fifo_wr_trigger(fifo_wr_trigger), .fifo_circular_depth(fifo_circular_depth),
    .fifo_wr_done(fifo_wr_done), .armed(armed), .triggered(triggered),
    .capture_done(capture_done), .overflow(overflow)
  );
  int checks = 0, failures = 0;
  bit ce[NC], trg[NC], wd[NC], ab[NC], ar[NC];
  logic [9:0] dat[NC];
  int pre, n, tmo;
  bit edg, lvl;
  logic [10:0] act_q[$], exp_q[$];
  int first_bad, rst_cnt, rst_first, act_trig_obs, exp_trig_obs, act_done_obs, exp_done_obs;
  bit exp_trig, exp_ov, exp_to, act_to, trig1, ov1;

  task automatic fill(int ce_pct);
    for (int c = 0; c < NC; c++) begin
      ce[c] = $urandom_range(99) < ce_pct;
      dat[c] = 10'($urandom);
      trg[c] = 0; wd[c] = 0; ab[c] = 0; ar[c] = 0;
    end
    tmo = 0;
  endtask

  // Sample-level reference: cycle 0 is the arm, cycles 1..4 the FIFO reset,
  // samples are processed from cycle 5 on.
  task automatic model();
    int ph, cnt, j, nn;
    bit prev, real_t, forced, tr;
    exp_q.delete(); exp_trig = 0; exp_ov = 0; exp_to = 0; exp_trig_obs = -1; exp_done_obs = -1;
    nn = n == 0 ? 1 : n;
    ph = pre == 0 ? 1 : 0;
    cnt = 0; j = 0; prev = ~lvl;
    for (int c = 1; c < NC; c++) begin
      if (c >= 5 && ph < 3) begin
        forced = ph == 1 && tmo != 0 && j >= tmo;
        real_t = ph == 1 && trg[c] == lvl && (!edg || prev != lvl);
        if (ph == 1) j++;
        if (ab[c]) ph = 3;
        else if (wd[c]) begin ph = 3; exp_ov = 1; exp_done_obs = c + 1; end
        else if (ce[c]) begin
          tr = real_t || forced;
          exp_q.push_back({tr, dat[c]});
          if (ph == 0) begin cnt++; if (cnt == pre) ph = 1; end
          else if (ph == 1) begin
            if (tr) begin
              exp_trig = 1; exp_to = forced && !real_t; exp_trig_obs = c + 1; cnt = 1;
              ph = nn == 1 ? 3 : 2;
              if (ph == 3) exp_done_obs = c + 1;
            end
          end else begin cnt++; if (cnt == nn) begin ph = 3; exp_done_obs = c + 1; end end
        end
      end
      if (ce[c]) prev = trg[c];
    end
  endtask

  task automatic run();
    int m;
    model();
    @(negedge clk);
    abort = 1; arm = 0; adc_ce = 0; fifo_wr_done = 0;
    presamples = pre; number_samples = n; trig_edge = edg; trig_level = lvl;
`ifdef CAPTURE_TIMEOUT_EN
    timeout_cycles = tmo;
`endif
    act_q.delete(); rst_cnt = 0; rst_first = -1; act_trig_obs = -1; act_done_obs = -1;
    for (int c = 0; c <= NC; c++) begin
      @(negedge clk);
      if (c > 0) begin
        if (fifo_wr_ce) act_q.push_back({fifo_wr_trigger, fifo_wr_data});
        if (fifo_rst) begin rst_cnt++; if (rst_first < 0) rst_first = c; end
        if (triggered && act_trig_obs < 0) act_trig_obs = c;
        if (capture_done && act_done_obs < 0) act_done_obs = c;
        if (c == 1) begin trig1 = triggered; ov1 = overflow; end
      end
      if (c < NC) begin
        abort = ab[c]; arm = c == 0 ? 1'b1 : ar[c]; adc_ce = ce[c]; adc_data = dat[c];
        trig_in = trg[c]; fifo_wr_done = wd[c];
      end else begin
        abort = 0; arm = 0; adc_ce = 0; fifo_wr_done = 0;
      end
    end
`ifdef CAPTURE_TIMEOUT_EN
    act_to = timed_out;
`else
    act_to = 0;
`endif
    m = act_q.size() > exp_q.size() ? act_q.size() : exp_q.size();
    first_bad = -1;
    for (int i = 0; i < m; i++)
      if (i >= act_q.size() || i >= exp_q.size() || act_q[i] !== exp_q[i]) begin first_bad = i; break; end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (fifo_rst !== 1'b1) begin failures++; $display("FAIL reset_fifo_rst: got %b want 1", fifo_rst); end
    checks++; if ({fifo_wr_ce, fifo_wr_trigger, armed, triggered, capture_done, overflow} !== 6'b0) begin
      failures++; $display("FAIL reset_status: got %b want 000000", {fifo_wr_ce, fifo_wr_trigger, armed, triggered, capture_done, overflow}); end
    checks++; if (fifo_circular_depth !== 0) begin failures++; $display("FAIL reset_depth: got %0d want 0", fifo_circular_depth); end
    rst = 0;
    @(negedge clk);
    checks++; if (fifo_rst !== 1'b0) begin failures++; $display("FAIL reset_release: got %b want 0", fifo_rst); end
  endtask

  task automatic test_level_capture();
    fill(100);
    for (int s = 0; s < 200; s++) if (5 + s < NC) dat[5 + s] = 10'(200 + s);
    dat[20] = 999; trg[20] = 1;
    pre = 3; n = 100; edg = 0; lvl = 1;
    run();
    checks++; if (rst_cnt !== 4 || rst_first !== 1) begin failures++; $display("FAIL level_fifo_rst: got %0d cycles from %0d want 4 from 1", rst_cnt, rst_first); end
    checks++; if (first_bad !== -1) begin failures++; $display("FAIL level_stream: first diff at %0d want none", first_bad); end
    checks++; if (act_q.size() !== 115) begin failures++; $display("FAIL level_count: got %0d want 115", act_q.size()); end
    checks++; if (act_q.size() <= 15 || act_q[15] !== {1'b1, 10'd999}) begin failures++; $display("FAIL level_trig_sample: got size %0d want 999 marked at 15", act_q.size()); end
    checks++; if (act_done_obs !== 120) begin failures++; $display("FAIL level_done_time: got %0d want 120", act_done_obs); end
    checks++; if (triggered !== 1'b1 || capture_done !== 1'b1) begin failures++; $display("FAIL level_status: got %b%b want 11", triggered, capture_done); end
    checks++; if (fifo_circular_depth !== 3) begin failures++; $display("FAIL level_depth: got %0d want 3", fifo_circular_depth); end
  endtask

  task automatic test_edge();
    fill(70);
    for (int c = 0; c < NC; c++) trg[c] = !(c >= 40 && c < 50);
    ce[45] = 1; ce[55] = 1;
    pre = 5; n = $urandom_range(1, 20); edg = 1; lvl = 1;
    run();
    checks++; if (first_bad !== -1) begin failures++; $display("FAIL edge_stream: first diff at %0d want none", first_bad); end
    checks++; if (act_trig_obs !== exp_trig_obs) begin failures++; $display("FAIL edge_trig_time: got %0d want %0d", act_trig_obs, exp_trig_obs); end
    checks++; if (act_done_obs !== exp_done_obs) begin failures++; $display("FAIL edge_done_time: got %0d want %0d", act_done_obs, exp_done_obs); end
  endtask

  task automatic test_prefill_ignore();
    fill(100);
    trg[7] = 1; trg[11] = 1; trg[17] = 1;
    pre = 10; n = 8; edg = 0; lvl = 1;
    run();
    checks++; if (first_bad !== -1) begin failures++; $display("FAIL prefill_stream: first diff at %0d want none", first_bad); end
    checks++; if (act_q.size() <= 12 || act_q[12] !== {1'b1, dat[17]}) begin failures++; $display("FAIL prefill_trig_sample: got size %0d want sample 12 marked", act_q.size()); end
    checks++; if (act_trig_obs !== 18) begin failures++; $display("FAIL prefill_trig_time: got %0d want 18", act_trig_obs); end
  endtask

  task automatic test_overflow();
    fill(100);
    trg[10] = 1;
    for (int c = 50; c < NC; c++) wd[c] = 1;
    pre = 2; n = 100; edg = 0; lvl = 1;
    run();
    checks++; if (first_bad !== -1) begin failures++; $display("FAIL ovf_stream: first diff at %0d want none", first_bad); end
    checks++; if (act_q.size() !== 45) begin failures++; $display("FAIL ovf_count: got %0d want 45", act_q.size()); end
    checks++; if (overflow !== 1'b1 || capture_done !== 1'b1) begin failures++; $display("FAIL ovf_status: got %b%b want 11", overflow, capture_done); end
    checks++; if (act_done_obs !== 51) begin failures++; $display("FAIL ovf_done_time: got %0d want 51", act_done_obs); end
  endtask

  task automatic test_abort();
    fill(80);
    pre = 3; n = 20; edg = 0; lvl = 1;
    ab[40] = 1;
    run();
    checks++; if (trig1 !== 1'b0 || ov1 !== 1'b0) begin failures++; $display("FAIL abort_arm_clear: got %b%b want 00", trig1, ov1); end
    checks++; if (first_bad !== -1) begin failures++; $display("FAIL abort_wait_stream: first diff at %0d want none", first_bad); end
    checks++; if (armed !== 1'b0 || capture_done !== 1'b0) begin failures++; $display("FAIL abort_idle: got %b%b want 00", armed, capture_done); end
    fill(80);
    pre = 3; n = 200; edg = 0; lvl = 1;
    ce[20] = 1; trg[20] = 1; ab[60] = 1;
    run();
    checks++; if (rst_cnt !== 4) begin failures++; $display("FAIL abort_rearm_rst: got %0d want 4", rst_cnt); end
    checks++; if (first_bad !== -1) begin failures++; $display("FAIL abort_post_stream: first diff at %0d want none", first_bad); end
    checks++; if (triggered !== 1'b1 || capture_done !== 1'b0) begin failures++; $display("FAIL abort_hold: got %b%b want 10", triggered, capture_done); end
  endtask

  task automatic test_arm_ignored();
    fill(90);
    ar[2] = 1; ar[15] = 1; ce[40] = 1; trg[40] = 1;
    pre = 20; n = 10; edg = 0; lvl = 1;
    run();
    checks++; if (rst_cnt !== 4) begin failures++; $display("FAIL armign_rst: got %0d want 4", rst_cnt); end
    checks++; if (first_bad !== -1) begin failures++; $display("FAIL armign_stream: first diff at %0d want none", first_bad); end
  endtask

  task automatic test_boundary();
    fill(100);
    pre = 0; n = 0; edg = 0; lvl = 0;
    run();
    checks++; if (act_q.size() !== 1 || first_bad !== -1) begin failures++; $display("FAIL bound_stream: got size %0d diff %0d want 1 none", act_q.size(), first_bad); end
    checks++; if (act_done_obs !== 6) begin failures++; $display("FAIL bound_done_time: got %0d want 6", act_done_obs); end
  endtask

  task automatic test_random();
    bit t;
    for (int k = 0; k < 6; k++) begin
      fill(60);
      t = 1'($urandom);
      for (int c = 0; c < NC; c++) begin if ($urandom_range(9) == 0) t = ~t; trg[c] = t; end
      if ($urandom_range(3) == 0) for (int c = $urandom_range(20, 150); c < NC; c++) wd[c] = 1;
      if ($urandom_range(3) == 0) ab[$urandom_range(5, 150)] = 1;
      pre = $urandom_range(0, 8); n = $urandom_range(0, 30); edg = 1'($urandom); lvl = 1'($urandom);
      run();
      checks++; if (first_bad !== -1) begin failures++; $display("FAIL rand%0d_stream: first diff at %0d want none", k, first_bad); end
      checks++; if ({triggered, overflow} !== {exp_trig, exp_ov}) begin failures++; $display("FAIL rand%0d_status: got %b%b want %b%b", k, triggered, overflow, exp_trig, exp_ov); end
      checks++; if (act_done_obs !== exp_done_obs) begin failures++; $display("FAIL rand%0d_done_time: got %0d want %0d", k, act_done_obs, exp_done_obs); end
    end
  endtask

`ifdef CAPTURE_TIMEOUT_EN
  task automatic test_timeout();
    fill(50);
    pre = 2; n = 10; edg = 0; lvl = 1; tmo = 50;
    run();
    checks++; if (first_bad !== -1) begin failures++; $display("FAIL tmo_stream: first diff at %0d want none", first_bad); end
    checks++; if (act_to !== exp_to || act_to !== 1'b1) begin failures++; $display("FAIL tmo_flag: got %b want 1", act_to); end
    checks++; if (capture_done !== 1'b1) begin failures++; $display("FAIL tmo_done: got %b want 1", capture_done); end
  endtask
`endif

  initial begin
    test_reset();
    test_level_capture();
    test_edge();
    test_prefill_ignore();
    test_overflow();
    test_abort();
    test_arm_ignored();
    test_boundary();
    test_random();
`ifdef CAPTURE_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
Single-clock capture controller placed in front of varwidth_fifo_withpre. It sequences one acquisition: FIFO reset, pre-trigger fill, trigger qualification and post-trigger sample counting. It gates the ADC sample stream into the FIFO and marks the trigger sample. Status bits go to the register block; FIFO readout is outside this block.

Parameters:
SAMPLE_W, 10, ADC sample width.
CNT_W, 32, width of the depth, count and timeout registers.
FIFO_RST_CYCLES, 4, length of the FIFO reset pulse issued on arm.

Ports:
clk  in  1  single system clock.
rst  in  1  synchronous, active-high reset.
arm  in  1  one-cycle pulse; starts a capture from IDLE or DONE, ignored otherwise.
abort  in  1  one-cycle pulse; returns to IDLE from any state.
trig_in  in  1  raw trigger, already synchronous to clk.
trig_level  in  1  active trigger level.
trig_edge  in  1  1 = edge mode (transition to trig_level), 0 = level mode.
presamples  in  CNT_W  required pre-trigger samples; drives the FIFO circular depth.
number_samples  in  CNT_W  post-trigger samples, trigger sample included; 0 is treated as 1.
adc_data  in  SAMPLE_W  sample.
adc_ce  in  1  sample valid.
fifo_rst  out  1  FIFO reset.
fifo_wr_data  out  SAMPLE_W  registered adc_data.
fifo_wr_ce  out  1  gated, registered adc_ce.
fifo_wr_trigger  out  1  marks the trigger sample.
fifo_circular_depth  out  CNT_W  presamples, latched on arm.
fifo_wr_done  in  1  FIFO full or done.
armed  out  1  state is PREFILL or WAIT_TRIG.
triggered  out  1  trigger accepted this capture; sticky until next arm.
capture_done  out  1  state is DONE.
overflow  out  1  fifo_wr_done seen before the count completed; sticky until next arm.

Behaviour:
- Reset: state IDLE. All outputs 0 except fifo_rst, which resets to 1 and is 0 from the first cycle after rst deasserts.
- Latching on arm: presamples and number_samples are latched. Input changes during a capture are ignored.
- Datapath: 1-cycle latency. fifo_wr_data <= adc_data every cycle. fifo_wr_ce <= adc_ce & gate. gate is 1 in PREFILL, WAIT_TRIG and POST.
- Trigger event, evaluated only when adc_ce=1:
  - level mode: trig_in==trig_level.
  - edge mode: trig_in==trig_level and trig_prev!=trig_level. trig_prev updates only on adc_ce cycles and is cleared to ~trig_level on arm.
- States:
  - IDLE: on arm -> FIFO_RST, and clear triggered and overflow.
  - FIFO_RST: fifo_rst=1 for FIFO_RST_CYCLES cycles, then -> PREFILL with pre_cnt=0.
  - PREFILL: pre_cnt increments per adc_ce. Triggers are ignored. When pre_cnt reaches presamples -> WAIT_TRIG. If presamples=0, go straight to WAIT_TRIG.
  - WAIT_TRIG: samples keep flowing into the FIFO (circular). On a trigger event with adc_ce: that sample is registered with fifo_wr_trigger=1 (same cycle as its fifo_wr_ce), triggered<=1, post_cnt<=1, -> POST. If post_cnt reaches number_samples on that same sample, go directly to DONE.
  - POST: post_cnt increments per adc_ce. The sample that makes post_cnt==number_samples is the last written -> DONE. fifo_wr_trigger stays 0.
  - DONE: gate=0, hold status. arm restarts the sequence via FIFO_RST.
- fifo_wr_done=1 in PREFILL, WAIT_TRIG or POST: overflow<=1 and -> DONE. The current input sample is not written.
- abort: -> IDLE next cycle. Gate closes immediately; a sample in flight in the register stage still completes. triggered and overflow are held.
- Simultaneous events:
  - arm together with abort: abort wins.
  - rst overrides everything.
  - arm in FIFO_RST, PREFILL, WAIT_TRIG or POST is ignored.
- Counters saturate at 2^CNT_W-1. Comparisons are equality on latched values.

Optional Feature:
Macro CAPTURE_TIMEOUT_EN.
- Defined: adds an input timeout_cycles (CNT_W) and an output timed_out.
  - A cycle counter runs in WAIT_TRIG. When it reaches timeout_cycles (nonzero), the next adc_ce sample is forced as the trigger and timed_out<=1 (sticky until arm).
  - timeout_cycles=0 disables the timeout.
- Undefined: no extra ports and no counter; only a real trigger event leaves WAIT_TRIG.

Decomposition:
- Package capture_pkg holds:
  - the state enum (IDLE, FIFO_RST, PREFILL, WAIT_TRIG, POST, DONE);
  - the CNT_W and SAMPLE_W defaults;
  - the FIFO_RST_CYCLES constant.
- One sub-module, trigger_qualifier. It holds trig_prev and the level/edge logic, and emits a trig_event pulse.
- FSM, counters and datapath stay in capture_sequencer.

Test Plan:
1. presamples=3, number_samples=100, level mode, trig_level=1, adc_ce every cycle, data 200.., trig_in high on sample 15 (value 999) -> fifo_rst pulse of 4 cycles; fifo_wr_trigger on the 999 sample; exactly 100 fifo_wr_ce from 999 onward; capture_done=1, triggered=1.
2. trig_in held high from arm, edge mode, presamples=5 -> no trigger until trig_in goes low then high; triggered stays 0 until that edge.
3. Trigger pulses during PREFILL (presamples=10, trigger on samples 2 and 6) -> ignored. Trigger on sample 12 is accepted, with fifo_wr_trigger on the sample-12 data.
4. fifo_wr_done asserted 40 samples into POST (number_samples=100) -> overflow=1, DONE next cycle, no further fifo_wr_ce.
5. abort during WAIT_TRIG, then arm -> IDLE after abort. After arm, a second fifo_rst pulse; triggered and overflow cleared on that arm.
6. CAPTURE_TIMEOUT_EN, timeout_cycles=50, no trigger -> forced fifo_wr_trigger on the first adc_ce after 50 WAIT_TRIG cycles; timed_out=1; capture completes normally.
